// File: rtl/conv_bank_sequencer.sv
// GPIO command front end for the 2D convolution datapath: fills a circular window of
// column banks, streams them oldest-to-newest to the convolutor and buffers its results.
module conv_bank_sequencer #(
    parameter int BIT_LEN    = 8,
    parameter int RAM_WIDTH  = 13,
    parameter int NB_ADDRESS = 10,
    parameter int N_BANKS    = 3,
    parameter int GPIO_D     = 32
) (
    input  logic                       i_CLK,
    input  logic                       i_reset,
    input  logic [GPIO_D-1:0]          i_gpio,
    output logic [GPIO_D-1:0]          o_gpio,
    output logic [N_BANKS*BIT_LEN-1:0] o_conv_data,
    output logic                       o_conv_valid,
    input  logic [RAM_WIDTH-1:0]       i_conv_data,
    input  logic                       i_conv_valid,
    output logic                       o_eop,
    output logic [2:0]                 o_led
);
    localparam int DEPTH  = 2 ** NB_ADDRESS;
    localparam int BANK_W = $clog2(N_BANKS);
    localparam int FILL_W = $clog2(N_BANKS + 1);

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_SET_LEN = 3'd1;
    localparam logic [2:0] CMD_LOAD    = 3'd2;
    localparam logic [2:0] CMD_RUN     = 3'd3;
    localparam logic [2:0] CMD_READ    = 3'd4;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    // Physical bank holding lane k: the window starts at the oldest bank (load_bank).
    function automatic logic [BANK_W-1:0] bank_of(input logic [BANK_W-1:0] base, input int k);
        logic [BANK_W:0] sum;
        sum = {1'b0, base} + (BANK_W+1)'(k);
        if (sum >= (BANK_W+1)'(N_BANKS))
            sum = sum - (BANK_W+1)'(N_BANKS);
        return sum[BANK_W-1:0];
    endfunction

    function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] f);
        return (f >= FILL_W'(N_BANKS)) ? f : f + 1'b1;
    endfunction

    state_t                     state;
    logic                       valid_q, err, busy_q, eop_q;
    logic [NB_ADDRESS:0]        len_q, res_ptr;
    logic [NB_ADDRESS-1:0]      wr_ptr, rd_addr, rd_ptr;
    logic [BANK_W-1:0]          load_bank;
    logic [FILL_W-1:0]          filled;
    logic [RAM_WIDTH-1:0]       rd_data;
    logic [N_BANKS*BIT_LEN-1:0] conv_data_p1, lanes;
    logic                       vld_p1;

    logic [RAM_WIDTH-1:0] bank_mem [N_BANKS][DEPTH];
    logic [RAM_WIDTH-1:0] result_mem [DEPTH];

    logic [2:0]           cmd;
    logic [RAM_WIDTH-1:0] data_word;
    logic [NB_ADDRESS:0]  len_arg, last_idx;
    logic                 accept, busy_st, len_ok, run_ok, load_we, cap_we, gpio_unused;

    assign cmd       = i_gpio[31:29];
    assign data_word = i_gpio[RAM_WIDTH:1];
    assign len_arg   = data_word[NB_ADDRESS:0];
    assign accept    = i_gpio[28] & ~valid_q;
    assign busy_st   = (state == STREAM) || (state == DRAIN);
    assign len_ok    = (len_arg != '0) && (len_arg <= (NB_ADDRESS+1)'(DEPTH));
    assign run_ok    = (filled == FILL_W'(N_BANKS)) && (wr_ptr == '0);
    assign last_idx  = len_q - 1'b1;
    assign load_we   = accept && (cmd == CMD_LOAD) && !busy_st;
    assign cap_we    = busy_st && i_conv_valid && (res_ptr < len_q);
    assign gpio_unused = ^{i_gpio[27:RAM_WIDTH+1], i_gpio[0]};

    always_ff @(posedge i_CLK) begin
        if (load_we)
            bank_mem[load_bank][wr_ptr] <= data_word;
        if (cap_we)
            result_mem[res_ptr[NB_ADDRESS-1:0]] <= i_conv_data;
    end

    always_comb begin
        lanes = '0;
        for (int k = 0; k < N_BANKS; k++)
            lanes[k*BIT_LEN +: BIT_LEN] = bank_mem[bank_of(load_bank, k)][rd_addr][BIT_LEN-1:0];
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state        <= IDLE;
            valid_q      <= 1'b0;
            err          <= 1'b0;
            busy_q       <= 1'b0;
            eop_q        <= 1'b0;
            len_q        <= (NB_ADDRESS+1)'(DEPTH);
            wr_ptr       <= '0;
            load_bank    <= '0;
            filled       <= '0;
            rd_addr      <= '0;
            rd_ptr       <= '0;
            res_ptr      <= '0;
            rd_data      <= '0;
            conv_data_p1 <= '0;
            vld_p1       <= 1'b0;
        end else begin
            valid_q <= i_gpio[28];
            // p1: bank read registered one cycle after its address is issued
            vld_p1  <= (state == STREAM);
            if (state == STREAM)
                conv_data_p1 <= lanes;
            if (cap_we)
                res_ptr <= res_ptr + 1'b1;

            case (state)
                STREAM: begin
                    rd_addr <= rd_addr + 1'b1;
                    if ({1'b0, rd_addr} == last_idx)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (res_ptr == len_q) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        eop_q  <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (accept) begin
                case (cmd)
                    CMD_NOP: ;
                    CMD_READ: begin
                        rd_data <= result_mem[rd_ptr];
                        rd_ptr  <= ({1'b0, rd_ptr} >= last_idx) ? '0 : rd_ptr + 1'b1;
                    end
                    CMD_SET_LEN: begin
                        if (busy_st || !len_ok) begin
                            err <= 1'b1;
                        end else begin
                            len_q     <= len_arg;
                            wr_ptr    <= '0;
                            load_bank <= '0;
                            filled    <= '0;
                            state     <= IDLE;
                            eop_q     <= 1'b0;
                        end
                    end
                    CMD_LOAD: begin
                        if (busy_st) begin
                            err <= 1'b1;
                        end else begin
                            if ({1'b0, wr_ptr} == last_idx) begin
                                wr_ptr    <= '0;
                                load_bank <= (load_bank == BANK_W'(N_BANKS - 1)) ? '0 : load_bank + 1'b1;
                                filled    <= sat_fill(filled);
                            end else begin
                                wr_ptr <= wr_ptr + 1'b1;
                            end
                            state <= IDLE;
                            eop_q <= 1'b0;
                        end
                    end
                    CMD_RUN: begin
                        if (busy_st || !run_ok) begin
                            err <= 1'b1;
                        end else begin
                            state   <= STREAM;
                            busy_q  <= 1'b1;
                            eop_q   <= 1'b0;
                            rd_addr <= '0;
                            res_ptr <= '0;
                            rd_ptr  <= '0;
                        end
                    end
                    default: err <= 1'b1;
                endcase
            end
        end
    end

    assign o_conv_data  = conv_data_p1;
    assign o_conv_valid = vld_p1;
    assign o_eop        = eop_q;
    assign o_led        = {eop_q, busy_q, err};

    always_comb begin
        o_gpio                = '0;
        o_gpio[RAM_WIDTH-1:0] = rd_data;
        o_gpio[31]            = busy_q;
        o_gpio[30]            = eop_q;
        o_gpio[29]            = err;
        o_gpio[28]            = valid_q;
    end
endmodule

// File: tb/tb_conv_bank_sequencer.sv
// Directed bench for conv_bank_sequencer: command-vector table for error cases plus
// hand-written sequences for streaming, result readback, window rotation and reset.
module tb_conv_bank_sequencer;
    logic        clk;
    logic        rst;
    logic [31:0] i_gpio;
    logic [31:0] o_gpio;
    logic [23:0] o_conv_data;
    logic        o_conv_valid;
    logic [12:0] i_conv_data;
    logic        i_conv_valid;
    logic        o_eop;
    logic [2:0]  o_led;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] NOP = 3'd0, SETL = 3'd1, LOAD = 3'd2, RUN = 3'd3, READ = 3'd4;

    conv_bank_sequencer dut (
        .i_CLK(clk), .i_reset(rst), .i_gpio(i_gpio), .o_gpio(o_gpio),
        .o_conv_data(o_conv_data), .o_conv_valid(o_conv_valid),
        .i_conv_data(i_conv_data), .i_conv_valid(i_conv_valid),
        .o_eop(o_eop), .o_led(o_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        logic       rst;
        logic [2:0] cmd;
        logic [12:0] data;
        int         rep;
        logic [2:0] exp_led;
    } vec_t;

    vec_t vec [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; i_gpio = '0; i_conv_valid = 1'b0; i_conv_data = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] cmd, input logic [12:0] data);
        @(posedge clk); #1;
        i_gpio = {cmd, 1'b1, 14'b0, data, 1'b0};
        @(posedge clk); #1;
        i_gpio[28] = 1'b0;
    endtask

    task automatic watch_stream(output int n, output logic [23:0] first);
        n = 0;
        first = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_conv_valid) begin
                if (n == 0) first = o_conv_data;
                n++;
            end
        end
    endtask

    initial begin
        int n;
        logic [23:0] first;
        logic seen;

        vec[0]  = '{1'b1, SETL, 13'd1,    1, 3'b000};
        vec[1]  = '{1'b0, LOAD, 13'd7,    2, 3'b000};
        vec[2]  = '{1'b0, RUN,  13'd0,    1, 3'b001};  // only 2 banks filled
        vec[3]  = '{1'b1, SETL, 13'd2,    1, 3'b000};
        vec[4]  = '{1'b0, LOAD, 13'd9,    7, 3'b000};
        vec[5]  = '{1'b0, RUN,  13'd0,    1, 3'b001};  // partial column
        vec[6]  = '{1'b1, SETL, 13'd0,    1, 3'b001};
        vec[7]  = '{1'b1, 3'd6, 13'd0,    1, 3'b001};
        vec[8]  = '{1'b1, SETL, 13'd1025, 1, 3'b001};
        vec[9]  = '{1'b1, SETL, 13'd1024, 1, 3'b000};
        vec[10] = '{1'b0, NOP,  13'd0,    1, 3'b000};

        rst = 1'b1; i_gpio = '0; i_conv_valid = 1'b0; i_conv_data = '0;
        repeat (2) @(posedge clk);
        do_reset();
        chk("reset gpio", o_gpio, 32'h0);
        chk("reset conv_data", {8'h0, o_conv_data}, 32'h0);
        chk("reset conv_valid", {31'h0, o_conv_valid}, 32'h0);
        chk("reset led", {29'h0, o_led}, 32'h0);
        chk("reset eop", {31'h0, o_eop}, 32'h0);

        // Main run: L=4, 12 words into 3 banks
        send(SETL, 13'd4);
        for (int i = 1; i <= 12; i++) send(LOAD, 13'(i));
        send(RUN, 13'd0);
        @(negedge clk);
        chk("stream latency valid", {31'h0, o_conv_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("stream%0d valid", i), {31'h0, o_conv_valid}, 32'h1);
            chk($sformatf("stream%0d lanes", i), {8'h0, o_conv_data},
                {8'h0, 8'(9 + i), 8'(5 + i), 8'(1 + i)});
        end
        @(negedge clk);
        chk("stream end valid", {31'h0, o_conv_valid}, 32'h0);
        chk("stream hold data", {8'h0, o_conv_data}, 32'h000C0804);
        chk("drain led", {29'h0, o_led}, 32'h2);

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            i_conv_valid = 1'b1;
            i_conv_data = 13'(100 + i);
        end
        @(posedge clk); #1;
        i_conv_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            if (o_eop) seen = 1'b1;
        end
        chk("eop after capture", {31'h0, seen}, 32'h1);
        chk("done led", {29'h0, o_led}, 32'h4);

        for (int i = 0; i < 5; i++) begin
            send(READ, 13'd0);
            chk($sformatf("read%0d gpio", i), o_gpio, 32'h5000_0000 | 32'(100 + (i % 4)));
        end
        @(posedge clk); #1;
        chk("ack follows valid low", {31'h0, o_gpio[28]}, 32'h0);

        // Sliding window: one new column replaces the oldest
        send(LOAD, 13'd13);
        chk("load leaves done", {31'h0, o_eop}, 32'h0);
        for (int i = 14; i <= 16; i++) send(LOAD, 13'(i));
        send(RUN, 13'd0);
        @(negedge clk);
        @(negedge clk);
        chk("rotated lanes", {8'h0, o_conv_data}, 32'h000D0905);
        send(LOAD, 13'd77);
        chk("load while busy led", {29'h0, o_led}, 32'h3);

        // Error vectors
        for (int i = 0; i < 11; i++) begin
            if (vec[i].rst) do_reset();
            for (int r = 0; r < vec[i].rep; r++) send(vec[i].cmd, vec[i].data + 13'(r));
            chk($sformatf("vec%0d led", i), {29'h0, o_led}, {29'h0, vec[i].exp_led});
        end

        // Level-held valid performs one LOAD only
        do_reset();
        send(SETL, 13'd2);
        @(posedge clk); #1;
        i_gpio = {LOAD, 1'b1, 14'b0, 13'd50, 1'b0};
        repeat (10) @(posedge clk);
        #1 i_gpio[28] = 1'b0;
        for (int i = 60; i <= 64; i++) send(LOAD, 13'(i));
        send(RUN, 13'd0);
        watch_stream(n, first);
        chk("held valid run led", {29'h0, o_led}, 32'h2);
        chk("held valid count", 32'(n), 32'd2);
        chk("held valid lanes", {8'h0, first}, 32'h003F3D32);

        // L=1 column; illegal SET_LEN keeps L and the filled banks
        do_reset();
        send(SETL, 13'd1);
        for (int i = 21; i <= 23; i++) send(LOAD, 13'(i));
        send(SETL, 13'd0);
        chk("setlen0 err", {29'h0, o_led}, 32'h1);
        send(RUN, 13'd0);
        watch_stream(n, first);
        chk("L1 count", 32'(n), 32'd1);
        chk("L1 lanes", {8'h0, first}, 32'h00171615);

        // Reset in the middle of STREAM
        do_reset();
        send(SETL, 13'd8);
        for (int i = 1; i <= 24; i++) send(LOAD, 13'(i));
        send(RUN, 13'd0);
        @(negedge clk);
        @(negedge clk);
        chk("midrun valid", {31'h0, o_conv_valid}, 32'h1);
        do_reset();
        chk("midrun reset valid", {31'h0, o_conv_valid}, 32'h0);
        chk("midrun reset gpio", o_gpio, 32'h0);
        chk("midrun reset data", {8'h0, o_conv_data}, 32'h0);
        chk("midrun reset eop", {31'h0, o_eop}, 32'h0);
        send(RUN, 13'd0);
        chk("run after reset led", {29'h0, o_led}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
